// File: rtl/nx_stream_serialiser_pkg.sv
// Shared link constants and types for the inter-node serialiser and its matching deserialiser.
// Optional feature macro used by the serialiser: NX_STREAM_SER_PARITY_EN.
package nx_stream_serialiser_pkg;

  localparam int LINK_WIDTH_DFLT = 8;

  typedef struct packed {
    logic [7:0]  dst_node;
    logic [7:0]  src_node;
    logic [15:0] payload;
  } node_message_t;

  localparam int NODE_MSG_W = $bits(node_message_t);

  typedef logic [LINK_WIDTH_DFLT-1:0] link_beat_t;

  // Callers zero-extend narrower beats; padding zeros leave the XOR unchanged.
  function automatic logic even_parity(input logic [NODE_MSG_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/nx_stream_serialiser_if.sv
// Inbound message stream plus outbound narrow link of the serialiser.
// The o_link_parity signal exists only when NX_STREAM_SER_PARITY_EN is defined.
interface nx_stream_serialiser_if #(
  parameter int LINK_WIDTH = nx_stream_serialiser_pkg::LINK_WIDTH_DFLT
);
  import nx_stream_serialiser_pkg::*;

  node_message_t         i_inbound_data;
  logic                  i_inbound_valid;
  logic                  o_inbound_ready;
  logic [LINK_WIDTH-1:0] o_link_data;
  logic                  o_link_valid;
  logic                  o_link_last;
  logic                  i_link_ready;
`ifdef NX_STREAM_SER_PARITY_EN
  logic                  o_link_parity;
`endif

  // master is the serialiser itself; slave is the environment around it
  modport master (
    input  i_inbound_data, i_inbound_valid, i_link_ready,
    output o_inbound_ready, o_link_data, o_link_valid, o_link_last
`ifdef NX_STREAM_SER_PARITY_EN
    , output o_link_parity
`endif
  );

  modport slave (
    output i_inbound_data, i_inbound_valid, i_link_ready,
    input  o_inbound_ready, o_link_data, o_link_valid, o_link_last
`ifdef NX_STREAM_SER_PARITY_EN
    , input o_link_parity
`endif
  );

endinterface

// File: rtl/nx_stream_serialiser.sv
// Splits node_message_t words into LINK_WIDTH-bit beats, LSB chunk first, with a last flag.
// Define NX_STREAM_SER_PARITY_EN to add an even-parity bit per beat.
module nx_stream_serialiser
  import nx_stream_serialiser_pkg::*;
#(
  parameter int LINK_WIDTH = LINK_WIDTH_DFLT
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  nx_stream_serialiser_if.master bus
);

  localparam int MSG_W = $bits(node_message_t);
  localparam int BEATS = (MSG_W + LINK_WIDTH - 1) / LINK_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PAD_W = BEATS * LINK_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      beat, beat_nxt;
  logic [PAD_W-1:0]      cap;
  logic                  load;
  logic                  last_beat;
  logic                  inbound_ready;
  logic                  in_hs;
  logic [LINK_WIDTH-1:0] link_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      beat  <= '0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      // Zero-extension keeps the bits above MSG_W in the final beat at 0
      if (load) cap <= PAD_W'(bus.i_inbound_data);
    end
  end

  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    load          = 1'b0;
    last_beat     = (state == SEND) && (beat == LAST_BEAT);
    inbound_ready = (state == IDLE) || (last_beat && bus.i_link_ready);
    in_hs         = bus.i_inbound_valid && inbound_ready;
    case (state)
      IDLE: begin
        if (in_hs) begin
          state_nxt = SEND;
          beat_nxt  = '0;
          load      = 1'b1;
        end
      end
      SEND: begin
        if (bus.i_link_ready) begin
          if (!last_beat) begin
            beat_nxt = beat + CNT_W'(1);
          end else if (in_hs) begin
            // Reload on the final beat so consecutive messages have no bubble
            beat_nxt = '0;
            load     = 1'b1;
          end else begin
            state_nxt = IDLE;
            beat_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  assign link_data = (state == SEND) ? cap[int'(beat) * LINK_WIDTH +: LINK_WIDTH] : '0;

  assign bus.o_inbound_ready = inbound_ready;
  assign bus.o_link_valid    = (state == SEND);
  assign bus.o_link_last     = last_beat;
  assign bus.o_link_data     = link_data;

`ifdef NX_STREAM_SER_PARITY_EN
  assign bus.o_link_parity = even_parity(NODE_MSG_W'(link_data));
`endif

endmodule

// File: tb/tb_nx_stream_serialiser.sv
// Directed bench for nx_stream_serialiser with a scoreboard of expected link beats.
// Parity checks are included when NX_STREAM_SER_PARITY_EN is defined.
module tb_nx_stream_serialiser;
  import nx_stream_serialiser_pkg::*;

  localparam int LW    = 8;
  localparam int MW    = $bits(node_message_t);
  localparam int BEATS = (MW + LW - 1) / LW;

  typedef struct packed {
    logic [LW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   run_len = 0;
  int   max_run = 0;
  beat_t exp_q[$];

  nx_stream_serialiser_if #(.LINK_WIDTH(LW)) bus ();

  nx_stream_serialiser #(.LINK_WIDTH(LW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && bus.o_link_valid && bus.i_link_ready) begin
      chk("beat_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", 32'(bus.o_link_data), 32'(e.data));
        chk("beat_last", 32'(bus.o_link_last), 32'(e.last));
        chk("ready_in_send", 32'(bus.o_inbound_ready), 32'(e.last));
`ifdef NX_STREAM_SER_PARITY_EN
        chk("beat_parity", 32'(bus.o_link_parity), 32'(^e.data));
`endif
      end
    end
    if (rst_n && bus.o_link_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic push_msg(input logic [MW-1:0] msg);
    logic [BEATS*LW-1:0] padded;
    padded = (BEATS*LW)'(msg);
    for (int b = 0; b < BEATS; b++)
      exp_q.push_back('{data: padded[b*LW +: LW], last: (b == BEATS-1)});
  endtask

  task automatic send(input logic [MW-1:0] msg);
    logic hs;
    bus.i_inbound_data  = node_message_t'(msg);
    bus.i_inbound_valid = 1'b1;
    push_msg(msg);
    hs = 1'b0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      hs = bus.o_inbound_ready;
      @(posedge clk);
      #1;
    end
    chk("inbound_handshake", 32'(hs), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.o_link_valid); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(bus.o_link_valid), 32'd0);
  endtask

  initial begin
    logic [MW-1:0] x;
    x = MW'(32'h1234_5678);
    rst_n = 1'b0;
    bus.i_inbound_data  = '0;
    bus.i_inbound_valid = 1'b0;
    bus.i_link_ready    = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.o_link_valid), 32'd0);
    chk("rst_ready", 32'(bus.o_inbound_ready), 32'd1);
    chk("rst_last", 32'(bus.o_link_last), 32'd0);
    chk("rst_data", 32'(bus.o_link_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.o_link_valid), 32'd0);
    chk("post_rst_ready", 32'(bus.o_inbound_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single message
    max_run = 0;
    send(x);
    bus.i_inbound_valid = 1'b0;
    chk("first_beat_valid", 32'(bus.o_link_valid), 32'd1);
    chk("first_beat_data", 32'(bus.o_link_data), 32'h78);
    drain();
    chk("single_run_len", 32'(max_run), 32'(BEATS));

    // Back-to-back
    repeat (2) @(posedge clk);
    #1;
    max_run = 0;
    send(x);
    send(~x);
    bus.i_inbound_valid = 1'b0;
    drain();
    chk("b2b_run_len", 32'(max_run), 32'(2*BEATS));

    // Backpressure on beat 1
    repeat (2) @(posedge clk);
    #1;
    send(x);
    bus.i_inbound_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.i_link_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.o_link_valid), 32'd1);
      chk("bp_data", 32'(bus.o_link_data), 32'h56);
      chk("bp_last", 32'(bus.o_link_last), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.i_link_ready = 1'b1;
    drain();

    // Mid-message reset after beat 1
    repeat (2) @(posedge clk);
    #1;
    send(x);
    bus.i_inbound_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.o_link_valid), 32'd0);
    chk("midrst_last", 32'(bus.o_link_last), 32'd0);
    chk("midrst_data", 32'(bus.o_link_data), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_rst_idle", 32'(bus.o_link_valid), 32'd0);
    send(MW'(32'h0000_00A5));
    bus.i_inbound_valid = 1'b0;
    chk("after_rst_beat0", 32'(bus.o_link_data), 32'hA5);
    drain();

    // Odd-parity beat
    send(MW'(32'h0000_0007));
    bus.i_inbound_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
